// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI initiator: one 16-bit address/rw/data frame per accepted request
module spi_master #(
    parameter int unsigned CLKDIV  = 2,
    parameter int unsigned CS_IDLE = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       miso_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       cs_o,
    output logic       sclk_o,
    output logic       mosi_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        TAIL,
        GUARD
    } state_e;

    // 17 bits holds the longest guard span (2*255*255 cycles) without wrapping
    localparam int unsigned GUARD_CYC  = 2 * CLKDIV * CS_IDLE;
    localparam logic [16:0] DIV_LAST   = 17'(CLKDIV - 1);
    localparam logic [16:0] GUARD_LAST = 17'(GUARD_CYC - 1);

    state_e      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [14:0] shreg_q, shreg_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        phase_end;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign phase_end = (cnt_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 17'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    // bit 15 goes straight to mosi; shreg keeps the remaining 15 bits
                    rw_d    = rw_i;
                    shreg_d = {addr_i[5:0], rw_i, (rw_i ? 8'h00 : wdata_i)};
                    mosi_d  = addr_i[6];
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (rw_q && bit_q[3]) begin
                        rx_d = {rx_q[6:0], miso_i};
                    end
                    if (bit_q == 4'd15) begin
                        mosi_d  = 1'b0;
                        state_d = TAIL;
                    end else begin
                        mosi_d  = shreg_q[14];
                        shreg_d = {shreg_q[13:0], 1'b0};
                        bit_d   = bit_q + 4'd1;
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            TAIL: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign cs_o    = cs_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a responder memory model per instance
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset [2];
    logic       start [2];
    logic       rw    [2];
    logic [6:0] addr  [2];
    logic [7:0] wdata [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] rdata [2];
    logic       cs    [2];
    logic       sclk  [2];
    logic       mosi  [2];

    logic [7:0] pre_mem [2][128];
    logic [7:0] model   [2][128];
    logic [7:0] last_rd [2];
    int         hi_run  [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          d;
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;
    exp_t sb_q[$];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic        miso;
        logic [15:0] rfr;
        int          rbit;
        logic        rrw;
        logic [6:0]  raddr;
        logic [7:0]  rbyte;
        logic [7:0]  wr_mem   [128];
        logic        wr_valid [128];
        logic        prev_cs   = 1'b1;
        logic        prev_sclk = 1'b0;

        spi_master #(
            .CLKDIV (g == 0 ? 2 : 1),
            .CS_IDLE(g == 0 ? 5 : 1)
        ) u_dut (
            .clk_i  (clk),
            .reset_i(reset[g]),
            .start_i(start[g]),
            .rw_i   (rw[g]),
            .addr_i (addr[g]),
            .wdata_i(wdata[g]),
            .miso_i (miso),
            .busy_o (busy[g]),
            .done_o (done[g]),
            .rdata_o(rdata[g]),
            .cs_o   (cs[g]),
            .sclk_o (sclk[g]),
            .mosi_o (mosi[g])
        );

        // Responder: shifts mosi on sclk rise, updates miso after sclk fall
        always @(negedge clk) begin
            if (cs[g] !== 1'b0) begin
                miso = 1'b0;
            end else if (prev_cs === 1'b1) begin
                rbit = 0;
                rfr  = '0;
            end else if (sclk[g] === 1'b1 && prev_sclk === 1'b0) begin
                rfr  = {rfr[14:0], mosi[g]};
                rbit = rbit + 1;
                if (rbit == 8) begin
                    raddr = rfr[7:1];
                    rrw   = rfr[0];
                    rbyte = (wr_valid[rfr[7:1]] === 1'b1) ? wr_mem[rfr[7:1]] : pre_mem[g][rfr[7:1]];
                end
                if (rbit == 16 && rrw === 1'b0) begin
                    wr_mem[raddr]   = rfr[7:0];
                    wr_valid[raddr] = 1'b1;
                end
            end else if (sclk[g] === 1'b0 && prev_sclk === 1'b1) begin
                if (rrw === 1'b1 && rbit >= 8 && rbit < 16) miso = rbyte[15 - rbit];
                else miso = 1'b0;
            end
            prev_cs   = cs[g];
            prev_sclk = sclk[g];
        end
    end

    function automatic logic [15:0] resp_frame(input int d);
        return (d == 0) ? gen_dut[0].rfr : gen_dut[1].rfr;
    endfunction

    function automatic int resp_bits(input int d);
        return (d == 0) ? gen_dut[0].rbit : gen_dut[1].rbit;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int d);
        for (int n = 0; n < 5000; n++) begin
            if (busy[d] === 1'b0) return;
            @(negedge clk);
            if (cs[d] === 1'b1) hi_run[d]++;
            else hi_run[d] = 0;
        end
        check("idle_timeout", 1, 0);
    endtask

    // inj: 0 plain frame, 1 extra start pulse mid-frame, 2 reset mid-frame
    task automatic run_frame(input int d, input logic r, input logic [6:0] a,
                             input logic [7:0] w, input int inj, output int gap);
        int div, idl, rises, cslow, ndone, first_rise, k_done, k_busy;
        logic prev_sclk;
        exp_t e;
        div = (d == 1) ? 1 : 2;
        idl = (d == 1) ? 1 : 5;
        rises = 0; cslow = 0; ndone = 0;
        first_rise = -1; k_done = -1; k_busy = -1;
        gap = 0;
        wait_idle(d);
        e.d     = d;
        e.frame = {a, r, (r ? 8'h00 : w)};
        if (r) last_rd[d] = model[d][a];
        else model[d][a] = w;
        e.rdata = last_rd[d];
        if (inj != 2) sb_q.push_back(e);
        start[d] = 1'b1; rw[d] = r; addr[d] = a; wdata[d] = w;
        @(negedge clk);
        start[d] = 1'b0; rw[d] = ~r; addr[d] = ~a; wdata[d] = ~w;
        gap = hi_run[d];
        prev_sclk = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (k > 0) @(negedge clk);
            if (cs[d] === 1'b1) hi_run[d]++;
            else hi_run[d] = 0;
            if (inj == 1 && k == 20) begin
                start[d] = 1'b1; rw[d] = 1'b1; addr[d] = 7'h7F; wdata[d] = 8'h00;
            end
            if (inj == 1 && k == 21) start[d] = 1'b0;
            if (inj == 2 && k == 30) begin
                reset[d] = 1'b1;
                #1;
                check("rst_cs", cs[d], 1);
                check("rst_sclk", sclk[d], 0);
                check("rst_busy", busy[d], 0);
                check("rst_rdata", rdata[d], 0);
                last_rd[d] = 8'h00;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done[d], 0);
                end
                reset[d] = 1'b0;
                return;
            end
            if (sclk[d] === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            prev_sclk = sclk[d];
            if (cs[d] === 1'b0) cslow++;
            if (done[d] === 1'b1) begin
                ndone++;
                if (k_done < 0) begin
                    k_done = k;
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 0, 1);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_dut", d, e.d);
                        check("sb_frame", resp_frame(d), e.frame);
                        check("sb_rdata", rdata[d], e.rdata);
                        check("sb_bits", resp_bits(d), 16);
                    end
                end
            end
            if (busy[d] === 1'b0) begin
                k_busy = k;
                break;
            end
        end
        check("first_rise", first_rise, div);
        check("rises", rises, 16);
        check("cs_low", cslow, 33 * div);
        check("done_at", k_done, 33 * div);
        check("done_width", ndone, 1);
        check("busy_fall", k_busy, 33 * div + 2 * div * idl);
    endtask

    initial begin
        int gap, hi;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; start[d] = 1'b0; rw[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; last_rd[d] = '0; hi_run[d] = 0;
            for (int i = 0; i < 128; i++) begin
                pre_mem[d][i] = 8'(i);
                model[d][i]   = 8'(i);
            end
        end
        pre_mem[0][7'h55] = 8'hAA; model[0][7'h55] = 8'hAA;
        pre_mem[0][7'h01] = 8'h00; model[0][7'h01] = 8'h00;
        pre_mem[1][7'h2A] = 8'h81; model[1][7'h2A] = 8'h81;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_cs", cs[d], 1);
            check("reset_sclk", sclk[d], 0);
            check("reset_mosi", mosi[d], 0);
            check("reset_busy", busy[d], 0);
            check("reset_done", done[d], 0);
            check("reset_rdata", rdata[d], 0);
        end
        reset[0] = 1'b0; reset[1] = 1'b0;
        @(negedge clk);

        run_frame(0, 1'b0, 7'h00, 8'hAA, 0, gap);
        run_frame(0, 1'b1, 7'h55, 8'h00, 0, gap);

        run_frame(0, 1'b0, 7'h01, 8'h3C, 0, gap);
        run_frame(0, 1'b1, 7'h01, 8'h00, 0, gap);
        check("b2b_cs_gap_ok", (gap >= 20), 1);
        check("b2b_rdata", rdata[0], 8'h3C);

        run_frame(0, 1'b0, 7'h12, 8'h5A, 1, gap);
        hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (cs[0] === 1'b1 && busy[0] === 1'b0) hi++;
        end
        check("no_second_frame", hi, 60);
        check("ignored_rdata", rdata[0], 8'h3C);

        run_frame(0, 1'b1, 7'h55, 8'h00, 2, gap);
        run_frame(0, 1'b1, 7'h55, 8'h00, 0, gap);
        check("post_reset_rdata", rdata[0], 8'hAA);

        run_frame(1, 1'b1, 7'h2A, 8'h00, 0, gap);
        check("min_div_rdata", rdata[1], 8'h81);
        run_frame(1, 1'b0, 7'h2A, 8'h42, 0, gap);
        run_frame(1, 1'b1, 7'h2A, 8'h00, 0, gap);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
